// File: rtl/alu_seq.sv
// Registered ALU with a valid/ready input handshake. Single-cycle logic/arith/shift ops
// plus WIDTH-cycle shift-add multiply and restoring divide, sequenced by a small FSM.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow,
    output logic             carry,
    output logic             zero,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_EQ   = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_MULU = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;
    logic [WIDTH-1:0] operand;

    logic accept;
    logic last_step;
    logic start_mul;
    logic start_div;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [32:0]      b_ext;
    logic             shift_big;
    logic [WIDTH-1:0] sc_result;
    logic [WIDTH-1:0] sc_result_hi;
    logic             sc_overflow;
    logic             sc_carry;
    logic             sc_dbz;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_fits;
    logic [WIDTH-1:0] div_hi_next;
    logic [WIDTH-1:0] div_lo_next;

    assign accept    = in_valid && in_ready;
    assign last_step = (count == CW'(WIDTH - 1));
    assign start_mul = accept && (op == OP_MULU);
    assign start_div = accept && (op == OP_DIVU) && (b != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (start_mul) begin
                    state_next = S_MUL;
                end else if (start_div) begin
                    state_next = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (last_step) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Everything that finishes on the accepting edge, including divide-by-zero.
    always_comb begin
        add_sum      = {1'b0, a} + {1'b0, b};
        sub_diff     = {1'b0, a} - {1'b0, b};
        b_ext        = 33'(b);
        shift_big    = (b_ext >= 33'(WIDTH));
        sc_result    = '0;
        sc_result_hi = '0;
        sc_overflow  = 1'b0;
        sc_carry     = 1'b0;
        sc_dbz       = 1'b0;
        case (op)
            OP_ADD: begin
                sc_result   = add_sum[WIDTH-1:0];
                sc_carry    = add_sum[WIDTH];
                sc_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result   = sub_diff[WIDTH-1:0];
                sc_carry    = sub_diff[WIDTH];
                sc_overflow = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT: sc_result = ~a;
            OP_AND: sc_result = a & b;
            OP_OR:  sc_result = a | b;
            OP_XOR: sc_result = a ^ b;
            OP_SLT: sc_result = WIDTH'($signed(a) < $signed(b));
            OP_EQ:  sc_result = WIDTH'(a == b);
            OP_SLL: sc_result = shift_big ? '0 : (a << b);
            OP_SRL: sc_result = shift_big ? '0 : (a >> b);
            OP_SRA: sc_result = shift_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> b);
            OP_DIVU: begin
                sc_result    = '1;
                sc_result_hi = a;
                sc_dbz       = 1'b1;
            end
            default: ;
        endcase
    end

    // One iteration of shift-add multiply (multiplier in work_lo) and restoring
    // divide (dividend shifting out of work_lo, partial remainder in work_hi).
    always_comb begin
        mul_sum     = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand} : '0);
        mul_hi_next = mul_sum[WIDTH:1];
        mul_lo_next = {mul_sum[0], work_lo[WIDTH-1:1]};
        div_shift   = {work_hi, work_lo[WIDTH-1]};
        div_diff    = div_shift - {1'b0, operand};
        div_fits    = !div_diff[WIDTH];
        div_hi_next = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_lo_next = {work_lo[WIDTH-2:0], div_fits};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            work_hi     <= '0;
            work_lo     <= '0;
            operand     <= '0;
            out_valid   <= 1'b0;
            result      <= '0;
            result_hi   <= '0;
            overflow    <= 1'b0;
            carry       <= 1'b0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_mul) begin
                        count   <= '0;
                        work_hi <= '0;
                        work_lo <= b;
                        operand <= a;
                    end else if (start_div) begin
                        count   <= '0;
                        work_hi <= '0;
                        work_lo <= a;
                        operand <= b;
                    end else if (accept) begin
                        out_valid   <= 1'b1;
                        result      <= sc_result;
                        result_hi   <= sc_result_hi;
                        overflow    <= sc_overflow;
                        carry       <= sc_carry;
                        zero        <= (sc_result == '0) && !sc_dbz;
                        div_by_zero <= sc_dbz;
                    end
                end
                S_MUL: begin
                    count   <= count + 1'b1;
                    work_hi <= mul_hi_next;
                    work_lo <= mul_lo_next;
                    if (last_step) begin
                        out_valid   <= 1'b1;
                        result      <= mul_lo_next;
                        result_hi   <= mul_hi_next;
                        overflow    <= 1'b0;
                        carry       <= 1'b0;
                        zero        <= ({mul_hi_next, mul_lo_next} == '0);
                        div_by_zero <= 1'b0;
                    end
                end
                S_DIV: begin
                    count   <= count + 1'b1;
                    work_hi <= div_hi_next;
                    work_lo <= div_lo_next;
                    if (last_step) begin
                        out_valid   <= 1'b1;
                        result      <= div_lo_next;
                        result_hi   <= div_hi_next;
                        overflow    <= 1'b0;
                        carry       <= 1'b0;
                        zero        <= (div_lo_next == '0);
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: hand-computed vectors checked with immediate
// assertions, sampled on the falling edge while inputs also change on the falling edge.
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic       overflow;
    logic       carry;
    logic       zero;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;
    int edges;
    int busy;
    int seen;

    alu_seq #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .result      (result),
        .result_hi   (result_hi),
        .overflow    (overflow),
        .carry       (carry),
        .zero        (zero),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one op for a single cycle (optionally keeping in_valid high with a
    // different op while busy), then waits a bounded time for out_valid.
    // edges = rising edges after the accepting edge; busy = cycles seen with in_ready low.
    task automatic apply_stimulus(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                  input bit poke_busy);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        if (poke_busy) begin
            op = 4'd0; a = 8'h11; b = 8'h22;
        end else begin
            in_valid = 1'b0;
        end
        edges = 0;
        busy  = 0;
        while (!out_valid && edges < 40) begin
            if (!in_ready) busy++;
            @(negedge clk);
            edges++;
        end
        in_valid = 1'b0;
        if (!out_valid) edges = -1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = 4'd0; a = 8'h00; b = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_outputs", {result, result_hi, overflow, carry, zero, div_by_zero}, 0);
        rst_n = 1'b1;

        apply_stimulus(4'd0, 8'h7F, 8'h01, 0);
        check("add_ovf_latency", edges, 0);
        check("add_ovf_result", {result_hi, result}, 16'h0080);
        check("add_ovf_flags", {overflow, carry, zero, div_by_zero}, 4'b1000);
        @(negedge clk);
        check("add_ovf_pulse_end", out_valid, 0);

        apply_stimulus(4'd0, 8'hFF, 8'h01, 0);
        check("add_carry_result", result, 8'h00);
        check("add_carry_flags", {overflow, carry, zero, div_by_zero}, 4'b0110);

        apply_stimulus(4'd1, 8'h00, 8'h01, 0);
        check("sub_borrow_result", result, 8'hFF);
        check("sub_borrow_flags", {overflow, carry, zero, div_by_zero}, 4'b0100);

        apply_stimulus(4'd1, 8'h80, 8'h01, 0);
        check("sub_ovf_result", result, 8'h7F);
        check("sub_ovf_flags", {overflow, carry, zero}, 3'b100);

        apply_stimulus(4'd6, 8'h80, 8'h01, 0);
        check("slt_signed", result, 8'h01);
        apply_stimulus(4'd7, 8'h5A, 8'h5B, 0);
        check("eq_false", {result, zero}, {8'h00, 1'b1});
        apply_stimulus(4'd5, 8'hF0, 8'h3C, 0);
        check("xor", result, 8'hCC);
        apply_stimulus(4'd2, 8'hA5, 8'h00, 0);
        check("not", result, 8'h5A);

        apply_stimulus(4'd10, 8'h80, 8'd3, 0);
        check("sra_3", result, 8'hF0);
        apply_stimulus(4'd9, 8'h80, 8'd9, 0);
        check("srl_9", {result, zero}, {8'h00, 1'b1});
        apply_stimulus(4'd8, 8'h01, 8'd7, 0);
        check("sll_7", result, 8'h80);
        apply_stimulus(4'd10, 8'h80, 8'd200, 0);
        check("sra_200", result, 8'hFF);
        apply_stimulus(4'd9, 8'h80, 8'd7, 0);
        check("srl_7", result, 8'h01);

        apply_stimulus(4'd14, 8'h12, 8'h34, 0);
        check("reserved", {result_hi, result, overflow, carry, zero, div_by_zero},
              {16'h0000, 4'b0010});

        // Multiply with in_valid held high throughout the busy window.
        apply_stimulus(4'd11, 8'hFF, 8'hFF, 1);
        check("mul_latency", edges, 8);
        check("mul_busy_cycles", busy, 8);
        check("mul_product", {result_hi, result}, 16'hFE01);
        check("mul_flags", {overflow, carry, zero, div_by_zero}, 4'b0000);
        check("mul_ready_after", in_ready, 1);
        @(negedge clk);
        check("mul_busy_ignored", out_valid, 0);

        apply_stimulus(4'd11, 8'h00, 8'h37, 0);
        check("mul_zero", {result_hi, result, zero}, {16'h0000, 1'b1});
        apply_stimulus(4'd11, 8'h0D, 8'h0B, 0);
        check("mul_small", {result_hi, result}, 16'h008F);

        apply_stimulus(4'd12, 8'h64, 8'h07, 0);
        check("div_latency", edges, 8);
        check("div_quot_rem", {result, result_hi}, 16'h0E02);
        check("div_flags", {zero, div_by_zero}, 2'b00);
        apply_stimulus(4'd12, 8'h05, 8'h09, 0);
        check("div_small", {result, result_hi, zero}, {16'h0005, 1'b1});

        apply_stimulus(4'd12, 8'h64, 8'h00, 0);
        check("div0_latency", edges, 0);
        check("div0_result", {result, result_hi}, 16'hFF64);
        check("div0_flags", {overflow, carry, zero, div_by_zero}, 4'b0001);

        // Reset while a multiply is in flight.
        @(negedge clk);
        op = 4'd11; a = 8'h0F; b = 8'h0F; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_outputs", {out_valid, result, result_hi, overflow, carry, zero, div_by_zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_out_valid", seen, 0);

        apply_stimulus(4'd0, 8'h02, 8'h03, 0);
        check("post_rst_latency", edges, 0);
        check("post_rst_add", {result_hi, result, carry, zero}, {16'h0005, 2'b00});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
